// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory with valid/ready request
// and response channels, byte-lane writes and a 2-entry response FIFO.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr              byte address (word = req_addr[DM_ADDRESS-1:2])
//   req_wdata/req_wstrb   lane-positioned write data and byte enables
//   rsp_valid/rsp_ready   response handshake (head of FIFO)
//   rsp_rdata             read word (0 for writes and errors)
//   rsp_write             echo of req_write
//   rsp_err               misaligned request flag

module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_write,
  output logic                  rsp_err
);

  localparam int IW    = DM_ADDRESS - 2;
  localparam int WORDS = 2 ** IW;

  logic [DATA_W-1:0] mem [WORDS];

  logic [1:0] occ;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       live;

  logic [DATA_W-1:0] ent_data  [2];
  logic              ent_write [2];
  logic              ent_err   [2];

  logic              accept;
  logic              pop;
  logic              misaligned;
  logic              do_write;
  logic              do_read;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] push_data;

  // live holds ready low until the first edge after reset release
  assign req_ready  = live && (occ < 2'd2);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (occ != 2'd0);
  assign pop        = rsp_valid && rsp_ready;

  assign idx        = req_addr[DM_ADDRESS-1:2];
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign do_write   = accept && req_write
                   && !misaligned && reset_n;
  assign do_read    = accept && !req_write
                   && !misaligned;

  assign push_data  = do_read ? mem[idx] : '0;

  // Byte-lane write port; memory is never reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Payload storage; outputs are gated by rsp_valid,
  // so stale entries never leak after reset
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_data[wr_ptr]  <= push_data;
      ent_write[wr_ptr] <= req_write;
      ent_err[wr_ptr]   <= misaligned;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live   <= 1'b0;
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign rsp_rdata = rsp_valid ? ent_data[rd_ptr] : '0;
  assign rsp_write = rsp_valid && ent_write[rd_ptr];
  assign rsp_err   = rsp_valid && ent_err[rd_ptr];

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + random bench for dmem_responder
// with a queue/array reference model.

module tb_dmem_responder;

  localparam int AW = 9;
  localparam int NW = 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_write;
  logic          rsp_err;

  dmem_responder #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        wr;
    logic        err;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mm [NW];
  bit          en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] old;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return en && (q.size() < 2);
  endfunction

  // Check outputs, advance one edge, update the model
  task automatic cyc();
    rsp_t e;
    bit   acc;
    bit   pp;
    int   w;
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rsp_rdata", rsp_rdata, q[0].rdata);
      chk("rsp_write", 32'(rsp_write), 32'(q[0].wr));
      chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
    end
    acc = req_valid && exp_ready();
    pp  = (q.size() != 0) && rsp_ready;
    @(posedge clk);
    if (!reset_n) begin
      en = 1'b0;
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        w       = int'(req_addr) / 4;
        e.wr    = req_write;
        e.err   = (int'(req_addr) % 4) != 0;
        e.rdata = 32'h0;
        if (!e.err) begin
          if (req_write) begin
            for (int b = 0; b < 4; b++)
              if (req_wstrb[b])
                mm[w][8*b +: 8] = req_wdata[8*b +: 8];
          end else begin
            e.rdata = mm[w];
          end
        end
        q.push_back(e);
      end
      en = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit w,
                       input logic [AW-1:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input bit rr);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    rsp_ready = rr;
    cyc();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  function automatic logic [AW-1:0] rnd_addr(input bit mis);
    int a;
    a = $urandom_range(0, NW - 1) * 4;
    if (mis && ($urandom_range(0, 7) == 0))
      a = a + $urandom_range(1, 3);
    return AW'(a);
  endfunction

  initial begin
    #1;
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_write", 32'(rsp_write), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();

    for (int i = 0; i < NW; i++)
      drive(1'b1, 1'b1, AW'(i * 4), $urandom, 4'hF, 1'b1);
    idle(1);

    drive(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b1);
    drive(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b1);
    chk("r032_valid", 32'(rsp_valid), 32'h1);
    chk("r032_rdata", rsp_rdata, 32'hDEADBEEF);
    idle(1);

    drive(1'b1, 1'b1, 9'h020, 32'h11223344, 4'hF, 1'b1);
    drive(1'b1, 1'b1, 9'h020, 32'h0000AA00, 4'b0010, 1'b1);
    drive(1'b1, 1'b0, 9'h020, 32'h0, 4'h0, 1'b1);
    chk("r033_rdata", rsp_rdata, 32'h1122AA44);
    idle(1);

    drive(1'b1, 1'b0, 9'h013, 32'h0, 4'h0, 1'b1);
    chk("r034_err", 32'(rsp_err), 32'h1);
    chk("r034_rdata", rsp_rdata, 32'h0);
    drive(1'b1, 1'b1, 9'h012, 32'hFFFFFFFF, 4'hF, 1'b1);
    drive(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b1);
    chk("r034_keep", rsp_rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 9'h020, 32'hFFFFFFFF, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 9'h020, 32'h0, 4'h0, 1'b1);
    chk("wstrb0_keep", rsp_rdata, 32'h1122AA44);
    drive(1'b1, 1'b1, 9'h1FC, $urandom, 4'b1001, 1'b1);
    drive(1'b1, 1'b0, 9'h1FC, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 9'h000, $urandom, 4'b0110, 1'b1);
    drive(1'b1, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1);
    idle(1);

    drive(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 9'h020, 32'h0, 4'h0, 1'b0);
    chk("r035_full", 32'(req_ready), 32'h0);
    drive(1'b1, 1'b0, 9'h1FC, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 9'h1FC, 32'h0, 4'h0, 1'b0);
    chk("r035_stall", rsp_rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 9'h1FC, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 9'h1FC, 32'h0, 4'h0, 1'b1);
    idle(3);

    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), rnd_addr(1'b0),
            $urandom, 4'($urandom), 1'b1);
    idle(2);

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), rnd_addr(1'b1),
            $urandom, 4'($urandom),
            1'($urandom_range(0, 3) != 0));
    idle(3);

    old = mm[12];
    drive(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 9'h020, 32'h0, 4'h0, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 9'h030;
    req_wdata = ~old;
    req_wstrb = 4'hF;
    reset_n   = 1'b0;
    #1;
    q.delete();
    en = 1'b0;
    chk("r037_valid", 32'(rsp_valid), 32'h0);
    chk("r037_ready", 32'(req_ready), 32'h0);
    chk("r037_rdata", rsp_rdata, 32'h0);
    chk("r037_write", 32'(rsp_write), 32'h0);
    chk("r037_err", 32'(rsp_err), 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    req_valid = 1'b0;
    drive(1'b1, 1'b0, 9'h030, 32'h0, 4'h0, 1'b1);
    chk("r037_keep", rsp_rdata, old);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, SHALL be the byte-address width; memory depth SHALL be 2**(DM_ADDRESS-2) 32-bit words.
REQ-002 Parameter DATA_W, default 32, SHALL be the data width; only 32 is supported.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port req_valid, input, 1, SHALL flag a request from the initiator.
REQ-006 Port req_ready, output, 1, SHALL flag that the responder can accept a request this cycle.
REQ-007 Port req_write, input, 1, SHALL select write (1) or read (0).
REQ-008 Port req_addr, input, DM_ADDRESS, SHALL be the byte address; word index = req_addr[DM_ADDRESS-1:2].
REQ-009 Port req_wdata, input, DATA_W, SHALL be the lane-positioned write word.
REQ-010 Port req_wstrb, input, 4, SHALL be the byte-lane write enables; bit i enables bits 8i+7..8i.
REQ-011 Port rsp_valid, output, 1, SHALL flag a valid response at the buffer head.
REQ-012 Port rsp_ready, input, 1, SHALL flag that the initiator takes the response.
REQ-013 Port rsp_rdata, output, DATA_W, SHALL be the full read word (0 for writes and errors).
REQ-014 Port rsp_write, output, 1, SHALL echo req_write of the responded request.
REQ-015 Port rsp_err, output, 1, SHALL flag a misaligned request (req_addr[1:0] != 0).

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_* are ignored otherwise.
REQ-017 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-018 Response buffer SHALL be a 2-entry FIFO; occupancy counter 0..2.
REQ-019 req_ready SHALL equal (occupancy < 2); combinational from registered occupancy only, independent of rsp_ready.
REQ-020 Accepted aligned write SHALL update memory bytes enabled by req_wstrb at the accepting edge; disabled lanes unchanged; wstrb=0 writes nothing but still responds.
REQ-021 Accepted aligned read SHALL capture mem[word] into the FIFO at the accepting edge; rsp_valid SHALL rise on the next cycle (latency 1) when the FIFO was empty.
REQ-022 Read accepted the cycle after a write to the same word SHALL return the written data.
REQ-023 Misaligned request SHALL NOT modify memory; response SHALL have rsp_err=1, rsp_rdata=0, rsp_write=req_write.
REQ-024 Aligned responses SHALL have rsp_err=0; write responses SHALL have rsp_rdata=0.
REQ-025 Response SHALL pop when rsp_valid && rsp_ready; rsp_* SHALL stay stable while rsp_valid && !rsp_ready.
REQ-026 Simultaneous accept and pop SHALL keep occupancy unchanged, including at occupancy 2 is not possible (req_ready=0); at occupancy 1 both occur, new entry becomes head next cycle.
REQ-027 FIFO pointers SHALL wrap modulo 2; occupancy SHALL never exceed 2 or underflow.
REQ-028 Memory SHALL have one write port and one synchronous read port; contents are not initialized and not reset.

Reset
REQ-029 While reset_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_err=0, occupancy=0, pointers=0.
REQ-030 reset_n assertion mid-operation SHALL discard buffered responses immediately; a write at an edge coinciding with reset_n=0 SHALL NOT occur.
REQ-031 req_ready SHALL rise on the first clk edge after reset_n deasserts.

Verification
REQ-032 Write 0xDEADBEEF wstrb=1111 to 0x010, then read 0x010 -> write rsp (err=0, rdata=0), then read rsp rdata=0xDEADBEEF one cycle after acceptance.
REQ-033 Preload 0x11223344 at 0x020, write 0x0000AA00 wstrb=0010, read -> 0x1122AA44.
REQ-034 Read 0x013 -> rsp_err=1, rdata=0; word 0x010 unchanged on subsequent read.
REQ-035 Hold rsp_ready=0, issue 3 reads back-to-back -> 2 accepted, req_ready=0 on third; release rsp_ready -> responses in order, stable while stalled, third accepted after first pop.
REQ-036 rsp_ready=1 continuous, one request per cycle for 16 cycles -> req_ready never drops, 16 responses, 1-cycle latency each.
REQ-037 Assert reset_n=0 with 2 buffered responses and a pending write -> rsp_valid=0 immediately, write target unchanged after reset.
